// File: rtl/mc_control_fsm.sv
// Multi-cycle RV32I main control: fetch/decode/exec/mem/wb sequencing, mux selects, write enables.
// Strobes are decoded from state and the opcode latched in DECODE; memory steps stall until mem_ack.
module mc_control_fsm #(
    parameter int CNT_W            = 32,
    parameter bit RESET_STATE_IDLE = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic [6:0]       opcode,
    input  logic             br_taken,
    input  logic             mem_ack,
    output logic             mem_req,
    output logic             mem_we,
    output logic             ir_write,
    output logic             pc_write,
    output logic             pc_src,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic [2:0]       imm_sel,
    output logic             reg_write,
    output logic [1:0]       wb_sel,
    output logic             retire,
    output logic [CNT_W-1:0] instret,
    output logic             trap,
    output logic [2:0]       state_o
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_TRAP   = 3'd6
    } state_t;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;

    state_t           state;
    state_t           state_nxt;
    state_t           retire_nxt;
    logic [6:0]       op_q;
    logic [CNT_W-1:0] instret_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= RESET_STATE_IDLE ? S_IDLE : S_FETCH;
            op_q      <= 7'd0;
            instret_q <= '0;
        end else begin
            state <= state_nxt;
            if (state == S_DECODE) begin
                op_q <= opcode;
            end
            if (retire) begin
                instret_q <= instret_q + CNT_W'(1);
            end
        end
    end

    assign instret = instret_q;
    assign trap    = (state == S_TRAP);
    assign state_o = state;

    always_comb begin
        state_nxt  = state;
        retire_nxt = run ? S_FETCH : S_IDLE;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        pc_src     = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        alu_op     = 2'b00;
        imm_sel    = 3'd0;
        reg_write  = 1'b0;
        wb_sel     = 2'b00;
        retire     = 1'b0;

        case (state)
            S_IDLE: begin
                if (run) begin
                    state_nxt = S_FETCH;
                end
            end
            S_FETCH: begin
                mem_req = 1'b1;
                if (mem_ack) begin
                    // PC advances by 4 through the ALU while IR captures the fetched word
                    ir_write  = 1'b1;
                    pc_write  = 1'b1;
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                    state_nxt = S_DECODE;
                end
            end
            S_DECODE: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b01;
                imm_sel   = 3'd2;
                case (opcode)
                    OP_R, OP_I, OP_LOAD, OP_STORE, OP_BR, OP_JAL, OP_JALR:
                        state_nxt = S_EXEC;
                    OP_LUI:  state_nxt = S_WB;
                    default: state_nxt = S_TRAP;
                endcase
            end
            S_EXEC: begin
                case (op_q)
                    OP_R: begin
                        alu_op    = 2'b10;
                        state_nxt = S_WB;
                    end
                    OP_I: begin
                        alu_src_b = 2'b01;
                        alu_op    = 2'b10;
                        state_nxt = S_WB;
                    end
                    OP_LOAD: begin
                        alu_src_b = 2'b01;
                        state_nxt = S_MEM;
                    end
                    OP_STORE: begin
                        alu_src_b = 2'b01;
                        imm_sel   = 3'd1;
                        state_nxt = S_MEM;
                    end
                    OP_BR: begin
                        alu_op    = 2'b01;
                        pc_write  = br_taken;
                        pc_src    = 1'b1;
                        retire    = 1'b1;
                        state_nxt = retire_nxt;
                    end
                    OP_JAL: begin
                        alu_src_a = 1'b1;
                        alu_src_b = 2'b01;
                        imm_sel   = 3'd4;
                        pc_write  = 1'b1;
                        pc_src    = 1'b1;
                        state_nxt = S_WB;
                    end
                    OP_JALR: begin
                        alu_src_b = 2'b01;
                        pc_write  = 1'b1;
                        pc_src    = 1'b1;
                        state_nxt = S_WB;
                    end
                    default: state_nxt = S_TRAP;
                endcase
            end
            S_MEM: begin
                mem_req = 1'b1;
                mem_we  = (op_q == OP_STORE);
                if (mem_ack) begin
                    if (op_q == OP_LOAD) begin
                        state_nxt = S_WB;
                    end else begin
                        retire    = 1'b1;
                        state_nxt = retire_nxt;
                    end
                end
            end
            S_WB: begin
                reg_write = 1'b1;
                retire    = 1'b1;
                state_nxt = retire_nxt;
                case (op_q)
                    OP_LOAD:          wb_sel = 2'b01;
                    OP_JAL, OP_JALR:  wb_sel = 2'b10;
                    OP_LUI: begin
                        alu_src_b = 2'b01;
                        imm_sel   = 3'd3;
                        alu_op    = 2'b11;
                    end
                    default:          wb_sel = 2'b00;
                endcase
            end
            S_TRAP: begin
                state_nxt = S_TRAP;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_mc_control_fsm.sv
// Scoreboard bench for mc_control_fsm: stimulus queues per-cycle expected outputs, a negedge monitor checks them.
// A 4-bit retire counter lets the wrap from all-ones to zero be reached by retiring 16 instructions.
module tb_mc_control_fsm;

    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          run;
    logic [6:0]    opcode;
    logic          br_taken;
    logic          mem_ack;
    logic          mem_req;
    logic          mem_we;
    logic          ir_write;
    logic          pc_write;
    logic          pc_src;
    logic          alu_src_a;
    logic [1:0]    alu_src_b;
    logic [1:0]    alu_op;
    logic [2:0]    imm_sel;
    logic          reg_write;
    logic [1:0]    wb_sel;
    logic          retire;
    logic [CW-1:0] instret;
    logic          trap;
    logic [2:0]    state_o;

    always #5 clk = ~clk;

    mc_control_fsm #(.CNT_W(CW), .RESET_STATE_IDLE(1'b1)) dut (
        .clk(clk), .rst(rst), .run(run), .opcode(opcode), .br_taken(br_taken),
        .mem_ack(mem_ack), .mem_req(mem_req), .mem_we(mem_we), .ir_write(ir_write),
        .pc_write(pc_write), .pc_src(pc_src), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .alu_op(alu_op), .imm_sel(imm_sel),
        .reg_write(reg_write), .wb_sel(wb_sel), .retire(retire), .instret(instret),
        .trap(trap), .state_o(state_o)
    );

    logic [24:0] exp_q[$];
    string       tag_q[$];
    int          n_cmp = 0;
    int          n_mis = 0;
    logic [3:0]  ret_cnt;
    logic        run_d;

    logic [20:0] V_IDLE, V_FNA, V_FA, V_DEC;
    logic [20:0] V_EXR, V_EXI, V_EXL, V_EXS, V_EXBT, V_EXBN, V_EXJ, V_EXJR;
    logic [20:0] V_MEML, V_MEMS, V_MEMSA;
    logic [20:0] V_WB0, V_WBL, V_WBJ, V_WBU, V_TRAP;

    // Field order: state, mem_req, mem_we, ir_write, pc_write, pc_src, alu_src_a,
    // alu_src_b, alu_op, imm_sel, reg_write, wb_sel, retire, trap
    function automatic logic [20:0] v(input int st, mr, mw, irw, pcw, pcs, asa,
                                      asb, aop, isel, rw, wbs, ret, trp);
        logic [20:0] r;
        r = {st[2:0], mr[0], mw[0], irw[0], pcw[0], pcs[0], asa[0], asb[1:0],
             aop[1:0], isel[2:0], rw[0], wbs[1:0], ret[0], trp[0]};
        return r;
    endfunction

    always @(negedge clk) begin
        logic [24:0] e;
        logic [24:0] act;
        string       t;
        if (exp_q.size() > 0) begin
            e   = exp_q.pop_front();
            t   = tag_q.pop_front();
            act = {instret, state_o, mem_req, mem_we, ir_write, pc_write, pc_src,
                   alu_src_a, alu_src_b, alu_op, imm_sel, reg_write, wb_sel, retire, trap};
            n_cmp++;
            if (act !== e) begin
                n_mis++;
                $display("FAIL %s @%0t: got %h expected %h (instret,state,strobes)",
                         t, $time, act, e);
            end
        end
    end

    task automatic step(input string t, input logic [6:0] op, input logic br,
                        input logic ack, input logic [20:0] e);
        run      = run_d;
        opcode   = op;
        br_taken = br;
        mem_ack  = ack;
        exp_q.push_back({ret_cnt, e});
        tag_q.push_back(t);
        if (e[1]) ret_cnt = ret_cnt + 4'd1;
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input int waits);
        for (int i = 0; i < waits; i++) step("fetch_wait", 7'h00, 1'b0, 1'b0, V_FNA);
        step("fetch_ack", 7'h00, 1'b0, 1'b1, V_FA);
    endtask

    task automatic do_reset();
        rst     = 1'b1;
        mem_ack = 1'b0;
        @(posedge clk);
        #1;
        rst     = 1'b0;
        ret_cnt = 4'd0;
    endtask

    initial begin
        V_IDLE = v(0,0,0,0,0,0,0,0,0,0,0,0,0,0);
        V_FNA  = v(1,1,0,0,0,0,0,0,0,0,0,0,0,0);
        V_FA   = v(1,1,0,1,1,0,1,2,0,0,0,0,0,0);
        V_DEC  = v(2,0,0,0,0,0,1,1,0,2,0,0,0,0);
        V_EXR  = v(3,0,0,0,0,0,0,0,2,0,0,0,0,0);
        V_EXI  = v(3,0,0,0,0,0,0,1,2,0,0,0,0,0);
        V_EXL  = v(3,0,0,0,0,0,0,1,0,0,0,0,0,0);
        V_EXS  = v(3,0,0,0,0,0,0,1,0,1,0,0,0,0);
        V_EXBT = v(3,0,0,0,1,1,0,0,1,0,0,0,1,0);
        V_EXBN = v(3,0,0,0,0,1,0,0,1,0,0,0,1,0);
        V_EXJ  = v(3,0,0,0,1,1,1,1,0,4,0,0,0,0);
        V_EXJR = v(3,0,0,0,1,1,0,1,0,0,0,0,0,0);
        V_MEML = v(4,1,0,0,0,0,0,0,0,0,0,0,0,0);
        V_MEMS = v(4,1,1,0,0,0,0,0,0,0,0,0,0,0);
        V_MEMSA= v(4,1,1,0,0,0,0,0,0,0,0,0,1,0);
        V_WB0  = v(5,0,0,0,0,0,0,0,0,0,1,0,1,0);
        V_WBL  = v(5,0,0,0,0,0,0,0,0,0,1,1,1,0);
        V_WBJ  = v(5,0,0,0,0,0,0,0,0,0,1,2,1,0);
        V_WBU  = v(5,0,0,0,0,0,0,1,3,3,1,0,1,0);
        V_TRAP = v(6,0,0,0,0,0,0,0,0,0,0,0,0,1);

        rst = 1'b1; run = 1'b0; opcode = 7'h00; br_taken = 1'b0; mem_ack = 1'b0;
        run_d = 1'b0; ret_cnt = 4'd0;
        @(posedge clk);
        #1;
        rst = 1'b0;

        // R-type, zero-wait memory; stray acks outside FETCH/MEM must be ignored
        run_d = 1'b1;
        step("idle_after_reset", 7'h00, 1'b0, 1'b1, V_IDLE);
        fetch(0);
        step("dec_r",  7'h33, 1'b0, 1'b1, V_DEC);
        step("exec_r", 7'h00, 1'b0, 1'b1, V_EXR);
        step("wb_r",   7'h00, 1'b0, 1'b1, V_WB0);

        // LOAD with one fetch wait and three MEM waits
        fetch(1);
        step("dec_ld",  7'h03, 1'b0, 1'b0, V_DEC);
        step("exec_ld", 7'h00, 1'b0, 1'b0, V_EXL);
        for (int i = 0; i < 3; i++) step("mem_ld_wait", 7'h00, 1'b0, 1'b0, V_MEML);
        step("mem_ld_ack", 7'h00, 1'b0, 1'b1, V_MEML);
        step("wb_ld",      7'h00, 1'b0, 1'b0, V_WBL);

        // BRANCH taken then not taken
        fetch(0);
        step("dec_br",   7'h63, 1'b0, 1'b0, V_DEC);
        step("exec_brt", 7'h00, 1'b1, 1'b0, V_EXBT);
        fetch(0);
        step("dec_br",   7'h63, 1'b1, 1'b0, V_DEC);
        step("exec_brn", 7'h00, 1'b0, 1'b0, V_EXBN);

        // LUI skips EXEC
        fetch(0);
        step("dec_lui", 7'h37, 1'b0, 1'b0, V_DEC);
        step("wb_lui",  7'h00, 1'b0, 1'b0, V_WBU);

        fetch(0);
        step("dec_jal",  7'h6F, 1'b0, 1'b0, V_DEC);
        step("exec_jal", 7'h00, 1'b0, 1'b0, V_EXJ);
        step("wb_jal",   7'h00, 1'b0, 1'b0, V_WBJ);

        fetch(0);
        step("dec_jalr",  7'h67, 1'b0, 1'b0, V_DEC);
        step("exec_jalr", 7'h00, 1'b0, 1'b0, V_EXJR);
        step("wb_jalr",   7'h00, 1'b0, 1'b0, V_WBJ);

        fetch(0);
        step("dec_ialu",  7'h13, 1'b0, 1'b0, V_DEC);
        step("exec_ialu", 7'h00, 1'b0, 1'b0, V_EXI);
        step("wb_ialu",   7'h00, 1'b0, 1'b0, V_WB0);

        fetch(0);
        step("dec_st",      7'h23, 1'b0, 1'b0, V_DEC);
        step("exec_st",     7'h00, 1'b0, 1'b0, V_EXS);
        step("mem_st_wait", 7'h00, 1'b0, 1'b0, V_MEMS);
        step("mem_st_ack",  7'h00, 1'b0, 1'b1, V_MEMSA);

        // run drops mid-LOAD: instruction completes, then IDLE
        fetch(0);
        step("dec_ld2",  7'h03, 1'b0, 1'b0, V_DEC);
        step("exec_ld2", 7'h00, 1'b0, 1'b0, V_EXL);
        step("mem_ld2",  7'h00, 1'b0, 1'b0, V_MEML);
        run_d = 1'b0;
        step("mem_ld2_norun", 7'h00, 1'b0, 1'b0, V_MEML);
        step("mem_ld2_ack",   7'h00, 1'b0, 1'b1, V_MEML);
        step("wb_ld2_norun",  7'h00, 1'b0, 1'b0, V_WBL);
        step("idle_parked",   7'h00, 1'b0, 1'b1, V_IDLE);
        step("idle_parked2",  7'h00, 1'b0, 1'b0, V_IDLE);

        // Illegal opcode traps, sticky until reset, no retire
        run_d = 1'b1;
        step("idle_go", 7'h00, 1'b0, 1'b0, V_IDLE);
        fetch(0);
        step("dec_ill", 7'h7F, 1'b0, 1'b0, V_DEC);
        for (int i = 0; i < 3; i++) step("trap_sticky", 7'h33, 1'b1, 1'b1, V_TRAP);
        do_reset();
        run_d = 1'b0;
        step("idle_after_trap_rst", 7'h00, 1'b0, 1'b0, V_IDLE);

        // 17 LUIs push the 4-bit counter through 15 -> 0 -> 1
        run_d = 1'b1;
        step("idle_go2", 7'h00, 1'b0, 1'b0, V_IDLE);
        for (int k = 0; k < 17; k++) begin
            fetch(0);
            step("dec_lui_w", 7'h37, 1'b0, 1'b0, V_DEC);
            step("wb_lui_w",  7'h00, 1'b0, 1'b0, V_WBU);
        end

        // Reset while MEM is waiting abandons the access
        fetch(0);
        step("dec_ld3",  7'h03, 1'b0, 1'b0, V_DEC);
        step("exec_ld3", 7'h00, 1'b0, 1'b0, V_EXL);
        step("mem_ld3",  7'h00, 1'b0, 1'b0, V_MEML);
        do_reset();
        run_d = 1'b0;
        step("idle_after_mem_rst", 7'h00, 1'b0, 1'b1, V_IDLE);

        @(negedge clk);
        #1;
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_mis++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
